// File: rtl/spi_flash_reader_if.sv
// ---------------------------------------------------------------------------
// spi_flash_reader_if
//   Bundles the request, byte-engine and output-stream signals of the
//   serial-flash read sequencer.
//
//   Handshake semantics (req_* and out_*): a transfer happens in every cycle
//   where valid and ready are both high at the rising clock edge. The producer
//   keeps valid and the payload stable until that cycle. Ready may depend on
//   state only, never on valid.
//
//   Signals:
//     req_valid/req_ready/req_addr/req_len : read request (addr, byte count)
//     busy                                 : sequencer working on a request
//     xfer_start/xfer_tx                   : byte launch towards the SPI engine
//     xfer_done/xfer_rx                    : byte completion from the engine
//     spi_cs_n                             : flash chip select, active low
//     out_valid/out_data/out_ready         : received-byte stream
//
//   Modports: slave = sequencer side, master = requester/engine/consumer side.
// ---------------------------------------------------------------------------
interface spi_flash_reader_if #(
    parameter int LEN_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [23:0]      req_addr;
    logic [LEN_W-1:0] req_len;
    logic             busy;
    logic             xfer_start;
    logic [7:0]       xfer_tx;
    logic             xfer_done;
    logic [7:0]       xfer_rx;
    logic             spi_cs_n;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_ready;

    modport slave (
        input  req_valid, req_addr, req_len, xfer_done, xfer_rx, out_ready,
        output req_ready, busy, xfer_start, xfer_tx, spi_cs_n, out_valid, out_data
    );

    modport master (
        output req_valid, req_addr, req_len, xfer_done, xfer_rx, out_ready,
        input  req_ready, busy, xfer_start, xfer_tx, spi_cs_n, out_valid, out_data
    );
endinterface

// File: rtl/spi_flash_reader.sv
// ---------------------------------------------------------------------------
// spi_flash_reader
//   Turns an (address, length) request into a serial-flash READ transaction:
//   opcode 0x03, 24-bit address MSB first, then one 0x00 byte per data byte.
//   Chip select is driven here; received data bytes are buffered in a small
//   FIFO and offered on a valid/ready stream.
//
//   Ports:
//     clk, reset   : clock, synchronous active-high reset
//     bus          : spi_flash_reader_if slave modport (request, byte engine,
//                    chip select, output stream)
//     dbg_state_o  : current FSM state encoding
// ---------------------------------------------------------------------------
module spi_flash_reader #(
    parameter int LEN_W   = 16,
    parameter int FIFO_AW = 4,
    parameter int CS_IDLE = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    spi_flash_reader_if.slave      bus,
    output logic [2:0]             dbg_state_o
);
    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int IDLE_W = (CS_IDLE < 2) ? 1 : $clog2(CS_IDLE + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CS_SETUP, S_CMD, S_A2, S_A1, S_A0, S_DATA, S_CS_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [23:0]        addr_q, addr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic               inflight_q, inflight_d;
    logic               busy_q, busy_d;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;

    logic accept, byte_state, done, push, fifo_pop, fifo_room;

    assign accept     = bus.req_valid && bus.req_ready;
    assign byte_state = (state_q == S_CMD) || (state_q == S_A2) || (state_q == S_A1) ||
                        (state_q == S_A0) || (state_q == S_DATA);
    // A done pulse only counts while a byte is outstanding.
    assign done       = bus.xfer_done && inflight_q;
    assign push       = done && (state_q == S_DATA);
    assign fifo_pop   = (count_q != '0) && bus.out_ready;
    // A pop in the same cycle frees the slot the next data byte will land in.
    assign fifo_room  = (count_q != (FIFO_AW + 1)'(DEPTH)) || fifo_pop;
    assign dbg_state_o = state_q;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            idle_cnt_q <= IDLE_W'(CS_IDLE);
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            idle_cnt_q <= idle_cnt_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (accept && (bus.req_len != '0)) state_d = S_CS_SETUP;
            S_CS_SETUP: state_d = S_CMD;
            S_CMD:      if (done) state_d = S_A2;
            S_A2:       if (done) state_d = S_A1;
            S_A1:       if (done) state_d = S_A0;
            S_A0:       if (done) state_d = S_DATA;
            S_DATA:     if (done && (rem_q == LEN_W'(1))) state_d = S_CS_HOLD;
            S_CS_HOLD:  state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        rem_d      = rem_q;
        inflight_d = inflight_q;
        idle_cnt_d = idle_cnt_q;
        if (accept) begin
            addr_d = bus.req_addr;
            rem_d  = bus.req_len;
        end
        if (bus.xfer_start)  inflight_d = 1'b1;
        else if (done)       inflight_d = 1'b0;
        if (push)            rem_d = rem_q - 1'b1;
        // Counts cycles with CS high; restarts as CS is released.
        if (state_q == S_CS_HOLD)
            idle_cnt_d = '0;
        else if ((state_q == S_IDLE) && (idle_cnt_q != IDLE_W'(CS_IDLE)))
            idle_cnt_d = idle_cnt_q + 1'b1;
        busy_d = accept || (state_d != S_IDLE);
    end

    // ---------------- outputs ----------------
    always_comb begin
        bus.req_ready = (state_q == S_IDLE) && !busy_q && (idle_cnt_q == IDLE_W'(CS_IDLE));
        bus.busy      = busy_q;
        bus.spi_cs_n  = (state_q == S_IDLE);
        bus.out_valid = (count_q != '0);
        bus.out_data  = mem_q[rd_ptr_q];
        case (state_q)
            S_CMD:   bus.xfer_tx = 8'h03;
            S_A2:    bus.xfer_tx = addr_q[23:16];
            S_A1:    bus.xfer_tx = addr_q[15:8];
            S_A0:    bus.xfer_tx = addr_q[7:0];
            default: bus.xfer_tx = 8'h00;
        endcase
        // Data bytes launch only when their result is guaranteed a FIFO slot.
        bus.xfer_start = byte_state && !inflight_q && ((state_q != S_DATA) || fifo_room);
    end

    // ---------------- receive FIFO ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)     wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, fifo_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.xfer_rx;
    end
endmodule

// File: tb/tb_spi_flash_reader.sv
// ---------------------------------------------------------------------------
// tb_spi_flash_reader
//   Self-checking bench: byte-engine model echoing 0xA0+n (n = byte index
//   within the chip-select window), scoreboards for transmitted bytes and
//   for the output stream, and directed request scenarios.
// ---------------------------------------------------------------------------
module tb_spi_flash_reader;
    logic       clk;
    logic       reset;
    logic [2:0] dbg_state;

    spi_flash_reader_if #(.LEN_W(16)) bus ();

    spi_flash_reader #(.LEN_W(16), .FIFO_AW(4), .CS_IDLE(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [7:0]  exp_q[$];     // expected output-stream bytes
    logic [7:0]  exp_tx_q[$];  // expected transmitted bytes
    int          out_mode     = 0; // 0 ready, 1 stalled, 2 toggle, 3 random
    logic        abort        = 1'b0;
    int          data_starts  = 0;
    int          cs_high_run  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- byte engine model ----------------
    initial begin : engine
        int   byte_n = 0;
        int   lat = 0;
        int   cyc = 0;
        int   last_done_cyc = 0;
        int   cs_low_cnt = 0;
        logic pending = 1'b0;
        logic cs_prev = 1'b1;
        bus.xfer_done = 1'b0;
        bus.xfer_rx   = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            bus.xfer_done = 1'b0;
            if (bus.spi_cs_n && !cs_prev && !abort)
                check("cs_hold", cyc - last_done_cyc, 2);
            if (!bus.spi_cs_n && cs_prev) abort = 1'b0;
            cs_prev = bus.spi_cs_n;
            if (bus.spi_cs_n) begin
                cs_high_run++;
                cs_low_cnt  = 0;
                byte_n      = 0;
                data_starts = 0;
            end else begin
                cs_high_run = 0;
                cs_low_cnt++;
            end
            if (reset) begin
                pending = 1'b0;
                byte_n  = 0;
            end else if (pending) begin
                if (bus.xfer_start) check("start_overlap", 1, 0);
                if (lat == 0) begin
                    bus.xfer_done = 1'b1;
                    bus.xfer_rx   = 8'hA0 + 8'(byte_n);
                    byte_n++;
                    pending       = 1'b0;
                    last_done_cyc = cyc;
                end else begin
                    lat--;
                end
            end else if (bus.xfer_start) begin
                if (bus.spi_cs_n) check("start_cs_high", 1, 0);
                if (byte_n == 0) check("cs_setup", cs_low_cnt, 2);
                if (byte_n >= 4) data_starts++;
                if (exp_tx_q.size() == 0) check("tx_unexp", 1, 0);
                else check("xfer_tx", bus.xfer_tx, exp_tx_q.pop_front());
                pending = 1'b1;
                lat     = $urandom_range(0, 2);
            end
        end
    end

    // ---------------- output consumer ----------------
    initial begin : consumer
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (out_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'b0;
                2:       bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (!reset && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("out_unexp", 1, 0);
                else check("out_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic [23:0] a, input logic [15:0] l, input logic gap_chk);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_len   = l;
        while (!bus.req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("req_wait", n < 2000, 1);
        if (gap_chk) check("cs_idle_gap", cs_high_run, 2);
        if (l != 0) begin
            exp_tx_q.push_back(8'h03);
            exp_tx_q.push_back(a[23:16]);
            exp_tx_q.push_back(a[15:8]);
            exp_tx_q.push_back(a[7:0]);
            for (int i = 0; i < int'(l); i++) begin
                exp_tx_q.push_back(8'h00);
                exp_q.push_back(8'hA4 + 8'(i));
            end
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy || exp_q.size() != 0 || exp_tx_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", n < 3000, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int n;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_cs_n",      bus.spi_cs_n,   1);
        check("rst_out_valid", bus.out_valid,  0);
        check("rst_busy",      bus.busy,       0);
        check("rst_req_ready", bus.req_ready,  1);
        check("rst_xfer_start", bus.xfer_start, 0);
        check("rst_xfer_tx",   bus.xfer_tx,    0);

        // Basic 3-byte read.
        out_mode = 0;
        send_req(24'h123456, 16'd3, 1'b0);
        wait_idle();

        // Zero-length request: one busy cycle, no chip-select activity.
        repeat (4) @(negedge clk);
        send_req(24'h000010, 16'd0, 1'b0);
        check("len0_busy",  bus.busy,     1);
        check("len0_cs_n",  bus.spi_cs_n, 1);
        @(negedge clk);
        check("len0_busy_clr", bus.busy,  0);
        check("len0_ready",    bus.req_ready, 1);

        // Backpressure: 20 bytes against a stalled consumer.
        out_mode = 1;
        send_req(24'hABCDEF, 16'd20, 1'b0);
        n = 0;
        while (data_starts < 16 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("bp_fill_timeout", n < 2000, 1);
        repeat (40) @(negedge clk);
        check("bp_starts",    data_starts,   16);
        check("bp_cs_low",    bus.spi_cs_n,  0);
        check("bp_out_valid", bus.out_valid, 1);
        out_mode = 0;
        wait_idle();

        // Back-to-back with valid held and a toggling consumer.
        out_mode = 2;
        send_req(24'h0A0B0C, 16'd4, 1'b0);
        send_req(24'hFEDCBA, 16'd5, 1'b1);
        wait_idle();

        // Reset in the middle of the address phase.
        out_mode = 0;
        repeat (4) @(negedge clk);
        send_req(24'h55AA33, 16'd6, 1'b0);
        n = 0;
        while (dbg_state != 3'd4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("a1_timeout", n < 200, 1);
        reset = 1'b1;
        abort = 1'b1;
        exp_q.delete();
        exp_tx_q.delete();
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_cs_n",      bus.spi_cs_n,   1);
        check("mid_rst_start",     bus.xfer_start, 0);
        check("mid_rst_out_valid", bus.out_valid,  0);
        check("mid_rst_busy",      bus.busy,       0);
        send_req(24'h010203, 16'd2, 1'b0);
        wait_idle();

        // Randomised requests with a random consumer.
        out_mode = 3;
        for (int k = 0; k < 4; k++) begin
            send_req(24'($urandom), 16'($urandom_range(1, 24)), 1'b0);
            wait_idle();
        end
        out_mode = 0;
        repeat (5) @(negedge clk);
        check("final_out_valid", bus.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
